// File: rtl/z80_bus_responder.sv
`timescale 1ns/1ps
// Memory-side responder for the Z80 core bus: internal block RAM with one-cycle
// registered reads, everything above it forwarded over an EXT_REQ/EXT_ACK handshake.
module z80_bus_responder #(
    parameter int unsigned RAM_AW  = 14,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  DO,
    input  logic        W,
    output logic [7:0]  DI,
    output logic        HOLD,
    output logic [15:0] EXT_ADDR,
    output logic [7:0]  EXT_WDATA,
    output logic        EXT_WE,
    output logic        EXT_REQ,
    input  logic        EXT_ACK,
    input  logic [7:0]  EXT_RDATA,
    output logic        ERR
);

    localparam int unsigned RAM_DEPTH  = 32'd1 << RAM_AW;
    localparam logic [7:0]  CNT_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        hold_q, hold_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic        ext_we_q, ext_we_d;
    logic        ext_req_q, ext_req_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [7:0]        ram_q [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rd;
    logic              ram_we;
    logic              is_int;

    assign ram_addr = A[RAM_AW-1:0];
    assign ram_rd   = ram_q[ram_addr];
    assign is_int   = ({16'd0, A} < RAM_DEPTH);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        di_d        = di_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_we_d    = ext_we_q;
        ext_req_d   = ext_req_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        ram_we      = 1'b0;

        case (state_q)
            // DONE samples the next access exactly like IDLE.
            ST_IDLE, ST_DONE: begin
                if (!hold_q) begin
                    hold_d = 1'b1;
                end else if (is_int) begin
                    di_d    = ram_rd;
                    ram_we  = W;
                    state_d = ST_IDLE;
                end else begin
                    ext_addr_d  = A;
                    ext_wdata_d = DO;
                    ext_we_d    = W;
                    ext_req_d   = 1'b1;
                    hold_d      = 1'b0;
                    cnt_d       = 8'd0;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (EXT_ACK) begin
                    ext_req_d = 1'b0;
                    if (!ext_we_q) begin
                        di_d = EXT_RDATA;
                    end
                    hold_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ext_req_d = 1'b0;
                    di_d      = 8'hFF;
                    err_d     = 1'b1;
                    hold_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            hold_q      <= 1'b0;
            di_q        <= 8'h00;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            ext_we_q    <= 1'b0;
            ext_req_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            di_q        <= di_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_we_q    <= ext_we_d;
            ext_req_q   <= ext_req_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; its contents
    // are undefined until written.
    always_ff @(posedge CLOCK) begin
        if (ram_we) begin
            ram_q[ram_addr] <= DO;
        end
    end

    assign DI        = di_q;
    assign HOLD      = hold_q;
    assign EXT_ADDR  = ext_addr_q;
    assign EXT_WDATA = ext_wdata_q;
    assign EXT_WE    = ext_we_q;
    assign EXT_REQ   = ext_req_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
`timescale 1ns/1ps
// Self-checking bench for z80_bus_responder: directed vector table, hand-written
// handshake/reset sequences, and random accesses against a transaction-level model.
module tb_z80_bus_responder;

    localparam int unsigned RAM_AW  = 14;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned RAM_SIZE = 32'd1 << RAM_AW;

    logic        CLOCK;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  DO;
    logic        W;
    logic [7:0]  DI;
    logic        HOLD;
    logic [15:0] EXT_ADDR;
    logic [7:0]  EXT_WDATA;
    logic        EXT_WE;
    logic        EXT_REQ;
    logic        EXT_ACK;
    logic [7:0]  EXT_RDATA;
    logic        ERR;

    z80_bus_responder #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .A(A), .DO(DO), .W(W), .DI(DI), .HOLD(HOLD),
        .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA), .EXT_WE(EXT_WE),
        .EXT_REQ(EXT_REQ), .EXT_ACK(EXT_ACK), .EXT_RDATA(EXT_RDATA), .ERR(ERR)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Transaction-level model: memory contents, last DI value, sticky error.
    logic [7:0] m_mem [int unsigned];
    logic [7:0] m_di;
    bit         m_di_ok;
    bit         m_err;

    task automatic model_predict(input logic [15:0] a, input logic w, input logic [7:0] d,
                                 input int ack_k, input logic [7:0] rd,
                                 output bit chk, output logic [7:0] exp_di,
                                 output int exp_stall, output logic exp_err);
        if (int'(a) < int'(RAM_SIZE)) begin
            exp_stall = 0;
            if (m_mem.exists(int'(a))) begin
                m_di    = m_mem[int'(a)];
                m_di_ok = 1'b1;
            end else begin
                m_di_ok = 1'b0;
            end
            if (w) m_mem[int'(a)] = d;
        end else if (ack_k < 1 || ack_k > int'(TIMEOUT)) begin
            exp_stall = TIMEOUT;
            m_di      = 8'hFF;
            m_di_ok   = 1'b1;
            m_err     = 1'b1;
        end else begin
            exp_stall = ack_k;
            if (!w) begin
                m_di    = rd;
                m_di_ok = 1'b1;
            end
        end
        chk     = m_di_ok;
        exp_di  = m_di;
        exp_err = m_err;
    endtask

    // One core access; ack_k = WAIT cycle on which the external side acks (0 = never).
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input int ack_k, input logic [7:0] rd,
                          input bit chk_di, input logic [7:0] exp_di,
                          input int exp_stall, input logic exp_err, input string tag);
        int stall;
        A = a; W = w; DO = d; EXT_ACK = 1'b0;
        tick();
        stall = 0;
        if (HOLD === 1'b0) begin
            check({tag, " req"},   32'(EXT_REQ),   32'd1);
            check({tag, " addr"},  32'(EXT_ADDR),  32'(a));
            check({tag, " we"},    32'(EXT_WE),    32'(w));
            check({tag, " wdata"}, 32'(EXT_WDATA), 32'(d));
            for (int c = 1; c <= int'(TIMEOUT) + 1; c++) begin
                EXT_ACK   = (c == ack_k);
                EXT_RDATA = (c == ack_k) ? rd : 8'($urandom);
                A  = 16'($urandom);
                W  = 1'($urandom);
                DO = 8'($urandom);
                tick();
                stall++;
                EXT_ACK = 1'b0;
                if (HOLD !== 1'b0) break;
                check({tag, " req held"},  32'(EXT_REQ),  32'd1);
                check({tag, " addr held"}, 32'(EXT_ADDR), 32'(a));
            end
        end
        check({tag, " stall"}, 32'(stall), 32'(exp_stall));
        check({tag, " hold"},  32'(HOLD), 32'd1);
        check({tag, " req off"}, 32'(EXT_REQ), 32'd0);
        if (chk_di) check({tag, " di"}, 32'(DI), 32'(exp_di));
        check({tag, " err"}, 32'(ERR), 32'(exp_err));
    endtask

    task automatic run_model(input logic [15:0] a, input logic w, input logic [7:0] d,
                             input int ack_k, input logic [7:0] rd, input string tag);
        bit chk; logic [7:0] e_di; int e_st; logic e_err;
        model_predict(a, w, d, ack_k, rd, chk, e_di, e_st, e_err);
        access(a, w, d, ack_k, rd, chk, e_di, e_st, e_err, tag);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        int          ack_k;
        logic [7:0]  rd;
        bit          chk_di;
        logic [7:0]  exp_di;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         chk;
        logic [7:0] e_di;
        int         e_st;
        logic       e_err;

        //          a         w     d      k  rd     chk   di     st err
        vecs[0]  = '{16'h0100, 1'b1, 8'h3E, 0, 8'h00, 1'b0, 8'h00, 0, 1'b0};
        vecs[1]  = '{16'h0200, 1'b1, 8'hAA, 0, 8'h00, 1'b0, 8'h00, 0, 1'b0};
        vecs[2]  = '{16'h0100, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h3E, 0, 1'b0};
        vecs[3]  = '{16'h0200, 1'b1, 8'h55, 0, 8'h00, 1'b1, 8'hAA, 0, 1'b0};
        vecs[4]  = '{16'h0200, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h55, 0, 1'b0};
        vecs[5]  = '{16'h3FFF, 1'b1, 8'h5A, 0, 8'h00, 1'b0, 8'h00, 0, 1'b0};
        vecs[6]  = '{16'h3FFF, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h5A, 0, 1'b0};
        vecs[7]  = '{16'h4000, 1'b0, 8'h00, 1, 8'hC3, 1'b1, 8'hC3, 1, 1'b0};
        vecs[8]  = '{16'h8000, 1'b0, 8'h00, 3, 8'h77, 1'b1, 8'h77, 3, 1'b0};
        vecs[9]  = '{16'hC001, 1'b1, 8'h12, 2, 8'hE7, 1'b1, 8'h77, 2, 1'b0};
        vecs[10] = '{16'h9000, 1'b0, 8'h00, 4, 8'h01, 1'b1, 8'h01, 4, 1'b0};
        vecs[11] = '{16'hA000, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'hFF, 4, 1'b1};
        vecs[12] = '{16'h0100, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h3E, 0, 1'b1};
        vecs[13] = '{16'hB000, 1'b0, 8'h00, 1, 8'h42, 1'b1, 8'h42, 1, 1'b1};
        vecs[14] = '{16'hF000, 1'b1, 8'h99, 0, 8'h00, 1'b1, 8'hFF, 4, 1'b1};
        vecs[15] = '{16'hE000, 1'b1, 8'h33, 1, 8'h00, 1'b1, 8'hFF, 1, 1'b1};

        m_di = 8'h00; m_di_ok = 1'b1; m_err = 1'b0;

        RESET = 1'b1; A = 16'h0; DO = 8'h0; W = 1'b0; EXT_ACK = 1'b0; EXT_RDATA = 8'h0;
        tick(); tick();
        check("rst di",    32'(DI),        32'h00);
        check("rst hold",  32'(HOLD),      32'd0);
        check("rst req",   32'(EXT_REQ),   32'd0);
        check("rst we",    32'(EXT_WE),    32'd0);
        check("rst addr",  32'(EXT_ADDR),  32'h0000);
        check("rst wdata", 32'(EXT_WDATA), 32'h00);
        check("rst err",   32'(ERR),       32'd0);
        RESET = 1'b0;
        tick();
        check("post-rst hold", 32'(HOLD), 32'd1);
        check("post-rst di",   32'(DI),   32'h00);

        foreach (vecs[i]) begin
            model_predict(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].ack_k, vecs[i].rd,
                          chk, e_di, e_st, e_err);
            access(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].ack_k, vecs[i].rd,
                   vecs[i].chk_di, vecs[i].exp_di, vecs[i].exp_stall, vecs[i].exp_err,
                   $sformatf("vec%0d", i));
        end

        // ACK on the REQ-raising edge is not seen; completion on the 2nd WAIT cycle.
        A = 16'h5000; W = 1'b0; DO = 8'h00; EXT_ACK = 1'b1; EXT_RDATA = 8'hEE;
        tick();
        EXT_ACK = 1'b0;
        check("early ack hold", 32'(HOLD),    32'd0);
        check("early ack req",  32'(EXT_REQ), 32'd1);
        tick();
        check("early ack still waiting", 32'(HOLD), 32'd0);
        EXT_ACK = 1'b1; EXT_RDATA = 8'h6D;
        tick();
        EXT_ACK = 1'b0;
        check("early ack done hold", 32'(HOLD), 32'd1);
        check("early ack done di",   32'(DI),   32'h6D);
        m_di = 8'h6D; m_di_ok = 1'b1;

        // ACK while in DONE and then IDLE must be ignored.
        A = 16'h0200; W = 1'b0; EXT_ACK = 1'b1; EXT_RDATA = 8'h11;
        tick();
        check("ack in done di",  32'(DI),      32'h55);
        check("ack in done req", 32'(EXT_REQ), 32'd0);
        A = 16'h0100;
        tick();
        EXT_ACK = 1'b0;
        check("ack in idle di",   32'(DI),      32'h3E);
        check("ack in idle hold", 32'(HOLD),    32'd1);
        check("ack in idle req",  32'(EXT_REQ), 32'd0);
        m_di = 8'h3E;

        // Random traffic against the model; the internal pool is written first.
        for (int i = 0; i < 16; i++) begin
            run_model((i < 8) ? 16'(i) : 16'(16'h3FF0 + i), 1'b1, 8'($urandom), 0, 8'h00,
                      $sformatf("init%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            int          idx;
            if ($urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, 15);
                a   = (idx < 8) ? 16'(idx) : 16'(16'h3FF0 + idx);
            end else begin
                a = 16'($urandom_range(32'h4000, 32'hFFFF));
            end
            run_model(a, 1'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT),
                      8'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset during the 2nd WAIT cycle abandons the transaction.
        A = 16'h8000; W = 1'b0; EXT_ACK = 1'b0;
        tick();
        check("rstwait entered", 32'(HOLD), 32'd0);
        tick();
        #1 RESET = 1'b1;
        #1;
        check("rstwait req",  32'(EXT_REQ), 32'd0);
        check("rstwait hold", 32'(HOLD),    32'd0);
        check("rstwait di",   32'(DI),      32'h00);
        check("rstwait err",  32'(ERR),     32'd0);
        #1 RESET = 1'b0;
        A = 16'h0100; W = 1'b0; EXT_ACK = 1'b1; EXT_RDATA = 8'hBD;
        tick();
        check("rstwait hold back", 32'(HOLD),    32'd1);
        check("rstwait di idle",   32'(DI),      32'h00);
        check("rstwait late ack",  32'(EXT_REQ), 32'd0);
        tick();
        EXT_ACK = 1'b0;
        check("rstwait read di",  32'(DI),      32'h3E);
        check("rstwait read req", 32'(EXT_REQ), 32'd0);
        check("rstwait read err", 32'(ERR),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Memory-side responder for the Z80 core's single-cycle bus (A/DO/W out of the core, DI/HOLD into it).
- Serves accesses below 2^RAM_AW from internal block RAM with 1-cycle registered read latency, matching the core's DI pipeline.
- Forwards all other addresses to a slow external memory over a REQ/ACK handshake, stalling the core via HOLD until the access completes or times out.

Parameters:
- RAM_AW, 14: internal RAM address width; internal region is 0x0000 .. 2^RAM_AW-1, the rest of the 64K space is external.
- TIMEOUT, 255: maximum WAIT cycles for EXT_ACK before abort (1..255, 8-bit counter).

Ports:
- CLOCK  in  1  system clock (100 MHz), all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- A  in  16  address from core.
- DO  in  8  write data from core.
- W  in  1  write strobe from core, 1 = write this cycle.
- DI  out  8  registered read data to core.
- HOLD  out  1  1 = core runs, 0 = core stalled.
- EXT_ADDR  out  16  latched external address.
- EXT_WDATA  out  8  latched external write data.
- EXT_WE  out  1  1 = external write, 0 = read; valid while EXT_REQ = 1.
- EXT_REQ  out  1  external request, level, held until ACK or timeout.
- EXT_ACK  in  1  external completion, one-cycle pulse.
- EXT_RDATA  in  8  external read data, valid with EXT_ACK.
- ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (async): DI = 0x00, HOLD = 0, EXT_REQ = 0, EXT_WE = 0, EXT_ADDR = 0x0000, EXT_WDATA = 0x00, ERR = 0, FSM = IDLE, timeout counter = 0.
  - RAM contents are not reset.
  - HOLD rises on the first CLOCK edge after RESET falls.
- FSM states: IDLE, WAIT, DONE.
- IDLE, HOLD = 1: A/W/DO are sampled every edge.
  - Internal address, W = 0: DI <= ram[A] at the edge; data is visible to the core the next cycle.
  - Internal address, W = 1: ram[A] <= DO at the edge. Read-first: DI <= the old ram[A] in the same edge.
  - External address: latch EXT_ADDR <= A, EXT_WDATA <= DO, EXT_WE <= W; set EXT_REQ <= 1 and HOLD <= 0; clear counter; go to WAIT. DI is unchanged.
- WAIT, HOLD = 0: A/W/DO are ignored; EXT_* outputs are stable.
  - EXT_ACK = 1: EXT_REQ <= 0; if EXT_WE = 0, DI <= EXT_RDATA; HOLD <= 1; go to DONE.
  - EXT_ACK = 0 and counter = TIMEOUT-1: EXT_REQ <= 0; DI <= 0xFF (reads and writes); ERR <= 1; HOLD <= 1; go to DONE.
  - Otherwise: counter increments.
- DONE, HOLD = 1: DI holds the completion value for exactly this cycle. The core's next access is sampled at this edge using IDLE rules, so back-to-back external accesses re-enter WAIT directly.
- External write completion leaves DI unchanged (only timeout forces 0xFF).
- EXT_ACK is sampled only in WAIT; ACK in IDLE/DONE is ignored.
  - An ACK on the same edge that raises EXT_REQ is not seen; earliest completion is 1 cycle after REQ is visible.
- Stall length: ACK on the k-th WAIT cycle gives HOLD = 0 for k cycles.
- ERR clears only on RESET.
- RESET during WAIT: EXT_REQ drops immediately (asynchronously); the transaction is abandoned and not retried.
- Address decode boundary: A = 2^RAM_AW-1 is internal; A = 2^RAM_AW is external. With RAM_AW = 16 everything is internal and the FSM never leaves IDLE.

Test Plan:
- Internal read: preload ram[0x0100] = 0x3E; drive A = 0x0100, W = 0 -> DI = 0x3E one cycle later, HOLD stays 1.
- Internal write then read: W = 1, A = 0x0200, DO = 0x55 with old value 0xAA -> DI = 0xAA next cycle; re-read 0x0200 -> DI = 0x55.
- External read: A = 0x8000, W = 0; responder returns ACK with RDATA = 0x77 on the 3rd WAIT cycle.
  - EXT_REQ = 1 and EXT_ADDR = 0x8000 for 3 cycles; HOLD = 0 for 3 cycles.
  - Then DI = 0x77, HOLD = 1, ERR = 0.
- External write: A = 0xC001, DO = 0x12, W = 1 -> EXT_WE = 1, EXT_WDATA = 0x12; after ACK, DI is unchanged and HOLD returns to 1.
- Timeout: TIMEOUT = 4, external read with ACK never asserted -> HOLD = 0 for 4 cycles, EXT_REQ drops, DI = 0xFF, ERR = 1 and stays 1 across later successful accesses.
- Reset mid-WAIT: assert RESET on the 2nd WAIT cycle -> EXT_REQ = 0, HOLD = 0, DI = 0x00 immediately; after release, HOLD = 1 next edge, internal read works, a late ACK is ignored.
